// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-file operand fetch stage with writeback override
// Optional feature macro: OPF_ZERO_R0_EN (register 0 always reads as zero)
module operand_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              wb_wren,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_rden_1,
  output logic              rf_rden_2,
  output logic [ADDR_W-1:0] rf_rdaddress_1,
  output logic [ADDR_W-1:0] rf_rdaddress_2,
  input  logic [DATA_W-1:0] rf_q_1,
  input  logic [DATA_W-1:0] rf_q_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [TAG_W-1:0]  out_tag
);

`ifdef OPF_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [DATA_W-1:0] ovr_a;
  logic [DATA_W-1:0] ovr_b;
  logic              ovr_a_vld;
  logic              ovr_b_vld;

  logic accept;
  logic hit_in_a;
  logic hit_in_b;
  logic hit_hold_a;
  logic hit_hold_b;
  logic zero_a;
  logic zero_b;

  // Handshake, RAM read-port drive and writeback address matches
  always_comb begin
    in_ready       = !flush && (!out_valid || out_ready);
    accept         = in_valid && in_ready;
    rf_rden_1      = accept;
    rf_rden_2      = accept;
    rf_rdaddress_1 = in_rs;
    rf_rdaddress_2 = in_rt;
    // The RAM returns old data on read-during-write, so a same-cycle write must be captured here
    hit_in_a       = wb_wren && (wb_addr == in_rs) && !(ZERO_R0 && (in_rs == '0));
    hit_in_b       = wb_wren && (wb_addr == in_rt) && !(ZERO_R0 && (in_rt == '0));
    // The RAM output is frozen while holding, so later writes to the held registers are captured too
    hit_hold_a     = wb_wren && (wb_addr == rs_q) && !(ZERO_R0 && (rs_q == '0));
    hit_hold_b     = wb_wren && (wb_addr == rt_q) && !(ZERO_R0 && (rt_q == '0));
    zero_a         = ZERO_R0 && (rs_q == '0);
    zero_b         = ZERO_R0 && (rt_q == '0);
  end

  // Operand select: override beats RAM data; invalid or r0-forced operands read as zero
  always_comb begin
    out_a = '0;
    out_b = '0;
    if (out_valid && !zero_a) out_a = ovr_a_vld ? ovr_a : rf_q_1;
    if (out_valid && !zero_b) out_b = ovr_b_vld ? ovr_b : rf_q_2;
  end

  // Held instruction state: flush beats accept, accept beats consume, consume beats hold
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      ovr_a     <= '0;
      ovr_b     <= '0;
      ovr_a_vld <= 1'b0;
      ovr_b_vld <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ovr_a_vld <= 1'b0;
      ovr_b_vld <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_tag   <= in_tag;
      rs_q      <= in_rs;
      rt_q      <= in_rt;
      ovr_a_vld <= hit_in_a;
      ovr_b_vld <= hit_in_b;
      if (hit_in_a) ovr_a <= wb_data;
      if (hit_in_b) ovr_b <= wb_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      ovr_a_vld <= 1'b0;
      ovr_b_vld <= 1'b0;
    end else if (out_valid) begin
      if (hit_hold_a) begin
        ovr_a     <= wb_data;
        ovr_a_vld <= 1'b1;
      end
      if (hit_hold_b) begin
        ovr_b     <= wb_data;
        ovr_b_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch with register-file RAM model
module tb_operand_fetch;

`ifdef OPF_ZERO_R0_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aclr;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_rs;
  logic [3:0] in_rt;
  logic [7:0] in_tag;
  logic       wb_wren;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;
  logic       rf_rden_1;
  logic       rf_rden_2;
  logic [3:0] rf_rdaddress_1;
  logic [3:0] rf_rdaddress_2;
  logic [7:0] rf_q_1;
  logic [7:0] rf_q_2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [7:0] out_tag;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  // Reference model: which instruction is held; operands are simply the architectural register values
  logic       m_valid = 1'b0;
  logic [3:0] m_rs = '0;
  logic [3:0] m_rt = '0;
  logic [7:0] m_tag = '0;

  typedef struct {
    logic       iv;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] tag;
    logic       ordy;
    logic       fl;
    logic       ww;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       ev;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] etag;
    logic       eirdy;
    logic       erden;
  } vec_t;

  vec_t tbl [25];

  operand_fetch dut (
    .clk(clk), .aclr(aclr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_tag(in_tag),
    .wb_wren(wb_wren), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_rden_1(rf_rden_1), .rf_rden_2(rf_rden_2),
    .rf_rdaddress_1(rf_rdaddress_1), .rf_rdaddress_2(rf_rdaddress_2),
    .rf_q_1(rf_q_1), .rf_q_2(rf_q_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Dual-read-port register file: registered read returns old data on read-during-write
  always @(posedge clk) begin
    if (rf_rden_1) rf_q_1 <= mem[rf_rdaddress_1];
    if (rf_rden_2) rf_q_2 <= mem[rf_rdaddress_2];
    if (wb_wren) mem[wb_addr] <= wb_data;
  end

  function automatic vec_t v(input logic iv, input logic [3:0] rs, input logic [3:0] rt,
                             input logic [7:0] tag, input logic ordy, input logic fl,
                             input logic ww, input logic [3:0] wa, input logic [7:0] wd,
                             input logic ev, input logic [7:0] ea, input logic [7:0] eb,
                             input logic [7:0] etag, input logic eirdy, input logic erden);
    vec_t r;
    r.iv = iv; r.rs = rs; r.rt = rt; r.tag = tag; r.ordy = ordy; r.fl = fl;
    r.ww = ww; r.wa = wa; r.wd = wd; r.ev = ev; r.ea = ea; r.eb = eb;
    r.etag = etag; r.eirdy = eirdy; r.erden = erden;
    return r;
  endfunction

  function automatic logic [7:0] ref_op(input logic [3:0] r);
    if (ZERO && r == 4'd0) return 8'h00;
    return mem[r];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic iv, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [7:0] tag, input logic ordy, input logic fl,
                        input logic ww, input logic [3:0] wa, input logic [7:0] wd);
    in_valid = iv; in_rs = rs; in_rt = rt; in_tag = tag; out_ready = ordy;
    flush = fl; wb_wren = ww; wb_addr = wa; wb_data = wd;
  endtask

  // Advance one clock, updating the transaction model from the inputs seen at the edge
  task automatic tick();
    logic rdy;
    @(posedge clk);
    if (!aclr) begin
      m_valid = 1'b0;
      m_tag   = '0;
    end else begin
      rdy = !flush && (!m_valid || out_ready);
      if (in_valid && rdy) begin
        m_valid = 1'b1; m_rs = in_rs; m_rt = in_rt; m_tag = in_tag;
      end else if (flush || (m_valid && out_ready)) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic model_check();
    logic rdy;
    rdy = !flush && (!m_valid || out_ready);
    chk("rnd_valid", 32'(out_valid), 32'(m_valid));
    chk("rnd_a", 32'(out_a), m_valid ? 32'(ref_op(m_rs)) : 32'd0);
    chk("rnd_b", 32'(out_b), m_valid ? 32'(ref_op(m_rt)) : 32'd0);
    if (m_valid) chk("rnd_tag", 32'(out_tag), 32'(m_tag));
    chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
    chk("rnd_rden_1", 32'(rf_rden_1), 32'(in_valid && rdy));
    chk("rnd_rden_2", 32'(rf_rden_2), 32'(in_valid && rdy));
  endtask

  initial begin
    // iv rs rt tag ordy fl ww wa wd | ev a b tag in_ready rden
    tbl[0]  = v(0,0,0,8'h00,1,0,1,3,8'h11, 0,8'h00,8'h00,8'h00,1,0);
    tbl[1]  = v(0,0,0,8'h00,1,0,1,5,8'h22, 0,8'h00,8'h00,8'h00,1,0);
    tbl[2]  = v(1,3,5,8'hA1,1,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,1);
    tbl[3]  = v(0,0,0,8'h00,1,0,0,0,8'h00, 1,8'h11,8'h22,8'hA1,1,0);
    tbl[4]  = v(0,0,0,8'h00,1,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,0);
    tbl[5]  = v(1,3,5,8'hB2,1,0,1,3,8'h99, 0,8'h00,8'h00,8'h00,1,1);
    tbl[6]  = v(0,0,0,8'h00,1,0,0,0,8'h00, 1,8'h99,8'h22,8'hB2,1,0);
    tbl[7]  = v(1,5,3,8'hC3,0,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,1);
    tbl[8]  = v(1,1,1,8'h00,0,0,1,5,8'h40, 1,8'h22,8'h99,8'hC3,0,0);
    tbl[9]  = v(0,0,0,8'h00,0,0,1,5,8'h41, 1,8'h40,8'h99,8'hC3,0,0);
    tbl[10] = v(0,0,0,8'h00,0,0,0,0,8'h00, 1,8'h41,8'h99,8'hC3,0,0);
    tbl[11] = v(0,0,0,8'h00,0,0,0,0,8'h00, 1,8'h41,8'h99,8'hC3,0,0);
    tbl[12] = v(0,0,0,8'h00,1,0,0,0,8'h00, 1,8'h41,8'h99,8'hC3,1,0);
    tbl[13] = v(0,0,0,8'h00,1,0,1,1,8'h01, 0,8'h00,8'h00,8'h00,1,0);
    tbl[14] = v(0,0,0,8'h00,1,0,1,2,8'h02, 0,8'h00,8'h00,8'h00,1,0);
    tbl[15] = v(0,0,0,8'h00,1,0,1,3,8'h03, 0,8'h00,8'h00,8'h00,1,0);
    tbl[16] = v(1,1,2,8'h01,1,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,1);
    tbl[17] = v(1,2,3,8'h02,1,0,0,0,8'h00, 1,8'h01,8'h02,8'h01,1,1);
    tbl[18] = v(1,3,1,8'h03,1,0,0,0,8'h00, 1,8'h02,8'h03,8'h02,1,1);
    tbl[19] = v(0,0,0,8'h00,1,0,0,0,8'h00, 1,8'h03,8'h01,8'h03,1,0);
    tbl[20] = v(0,0,0,8'h00,1,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,0);
    tbl[21] = v(1,5,3,8'hD4,1,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,1);
    tbl[22] = v(0,0,0,8'h00,0,0,0,0,8'h00, 1,8'h41,8'h03,8'hD4,0,0);
    tbl[23] = v(1,5,3,8'hEE,0,1,0,0,8'h00, 1,8'h41,8'h03,8'hD4,0,0);
    tbl[24] = v(0,0,0,8'h00,0,0,0,0,8'h00, 0,8'h00,8'h00,8'h00,1,0);

    aclr = 1'b0;
    set_in(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    #2;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_a", 32'(out_a), 32'd0);
    chk("reset_b", 32'(out_b), 32'd0);
    chk("reset_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    aclr = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) begin
      set_in(tbl[i].iv, tbl[i].rs, tbl[i].rt, tbl[i].tag, tbl[i].ordy, tbl[i].fl,
             tbl[i].ww, tbl[i].wa, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d_a", i), 32'(out_a), 32'(tbl[i].ea));
      chk($sformatf("row%0d_b", i), 32'(out_b), 32'(tbl[i].eb));
      if (tbl[i].ev) chk($sformatf("row%0d_tag", i), 32'(out_tag), 32'(tbl[i].etag));
      chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].eirdy));
      chk($sformatf("row%0d_rden_1", i), 32'(rf_rden_1), 32'(tbl[i].erden));
      chk($sformatf("row%0d_rden_2", i), 32'(rf_rden_2), 32'(tbl[i].erden));
      if (tbl[i].erden) begin
        chk($sformatf("row%0d_rdaddr_1", i), 32'(rf_rdaddress_1), 32'(tbl[i].rs));
        chk($sformatf("row%0d_rdaddr_2", i), 32'(rf_rdaddress_2), 32'(tbl[i].rt));
      end
      tick();
    end

    // Register 0: preload 0x55, then write 0x77 on the accept cycle of rs=rt=0
    set_in(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h55);
    tick();
    set_in(1, 0, 0, 8'hE5, 1, 0, 1, 0, 8'h77);
    tick();
    set_in(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    @(negedge clk);
    chk("r0_valid", 32'(out_valid), 32'd1);
    chk("r0_a", 32'(out_a), ZERO ? 32'h00 : 32'h77);
    chk("r0_b", 32'(out_b), ZERO ? 32'h00 : 32'h77);
    chk("r0_tag", 32'(out_tag), 32'hE5);
    tick();

    // Asynchronous reset while an instruction is stalled
    set_in(1, 5, 3, 8'hF6, 0, 0, 0, 0, 8'h00);
    tick();
    set_in(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    tick();
    @(negedge clk);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_tag", 32'(out_tag), 32'hF6);
    #2;
    aclr = 1'b0;
    #1;
    chk("aclr_valid", 32'(out_valid), 32'd0);
    chk("aclr_a", 32'(out_a), 32'd0);
    chk("aclr_b", 32'(out_b), 32'd0);
    chk("aclr_tag", 32'(out_tag), 32'd0);
    tick();
    aclr = 1'b1;

    // Give every register a defined value before the random phase
    for (int r = 0; r < 16; r++) begin
      set_in(0, 0, 0, 8'h00, 1, 0, 1, 4'(r), 8'($urandom));
      tick();
    end

    // Randomized traffic over a few registers so hazards are frequent
    for (int n = 0; n < 1500; n++) begin
      set_in(($urandom % 4) != 0, 4'($urandom % 4), 4'($urandom % 4), 8'($urandom),
             ($urandom % 3) != 0, ($urandom % 16) == 0,
             ($urandom % 2) != 0, 4'($urandom % 4), 8'($urandom));
      @(negedge clk);
      model_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute stage sitting directly downstream of the dual-read-port register file RAM in the 8-bit MIPS datapath.
- Accepts a decoded instruction's two source register addresses and drives the RAM's two read ports.
- Absorbs the RAM's one-cycle registered-read latency and resolves read-during-write hazards from the writeback port.
- Presents both operands to execute with a valid/ready handshake and holds them correctly through stalls.

Parameters:
- DATA_W, 8: register/operand width.
- ADDR_W, 4: register address width (16 registers).
- TAG_W, 8: width of opaque instruction sideband (opcode, rd, imm) carried alongside operands.

Ports:
- clk  in  1  clock; all state on rising edge.
- aclr  in  1  asynchronous active-low reset; 0 resets immediately, release synchronous to clk.
- flush  in  1  synchronous squash of the held instruction.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_rs  in  ADDR_W  source A register.
- in_rt  in  ADDR_W  source B register.
- in_tag  in  TAG_W  sideband.
- wb_wren  in  1  snoop of register-file write enable.
- wb_addr  in  ADDR_W  snoop of register-file write address.
- wb_data  in  DATA_W  snoop of register-file write data.
- rf_rden_1  out  1  read enable, port 1.
- rf_rden_2  out  1  read enable, port 2.
- rf_rdaddress_1  out  ADDR_W  read address, port 1.
- rf_rdaddress_2  out  ADDR_W  read address, port 2.
- rf_q_1  in  DATA_W  RAM read data, port 1; valid one cycle after rden; held while rden=0.
- rf_q_2  in  DATA_W  RAM read data, port 2; same timing as rf_q_1.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute consumes.
- out_a  out  DATA_W  operand A.
- out_b  out  DATA_W  operand B.
- out_tag  out  TAG_W  sideband.

Behaviour:
- Reset (aclr=0): out_valid=0, out_tag=0, held rs/rt=0, override flags cleared. out_a and out_b read 0, since they are forced to 0 whenever out_valid=0.
- Handshake and latency:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - On accept cycle: rf_rden_1/2=1; rf_rdaddress_1=in_rs, rf_rdaddress_2=in_rt (combinational pass-through); capture rs, rt, tag.
  - Next cycle out_valid=1. Latency in→out is exactly 1 cycle; throughput 1/cycle when out_ready=1.
  - rf_rden_x=0 on all non-accept cycles, so RAM q holds the captured value during stalls. rf_rdaddress_x still follow in_rs/in_rt (don't-care).
- Operand select, per port: out_a = ovr_a_vld ? ovr_a : rf_q_1. out_b is the same using ovr_b / rf_q_2.
- Override capture:
  - RAM returns OLD data on read-during-write. On the accept cycle, if wb_wren && wb_addr==in_rs, then ovr_a<=wb_data and ovr_a_vld<=1; otherwise ovr_a_vld<=0.
  - While holding (out_valid && !out_ready), if wb_wren && wb_addr==held rs, then ovr_a<=wb_data and ovr_a_vld<=1. Newest write wins.
  - Port B is identical with rt.
  - If rs==rt, both ports capture the same write.
- Simultaneous events:
  - Consume and accept in the same cycle: the new instruction replaces the old and overrides are recomputed for the new one only.
  - Consume with no accept: out_valid<=0, ovr flags cleared.
  - flush=1: out_valid<=0, ovr flags cleared, no accept that cycle, regardless of out_ready.
- Reset mid-stall discards the held instruction. No output glitch beyond out_valid dropping asynchronously.

Optional Feature:
- Macro OPF_ZERO_R0_EN.
- Defined: register address 0 always reads as 0. Any operand whose captured address is 0 outputs 0, regardless of RAM contents or wb writes to address 0, and overrides never set for address 0.
- Undefined: address 0 is an ordinary register, including override behaviour.

Test Plan:
- Preload r3=0x11, r5=0x22. Accept rs=3, rt=5, tag=0xA1, out_ready=1 → next cycle out_valid=1, out_a=0x11, out_b=0x22, out_tag=0xA1; rden pulsed for exactly 1 cycle.
- Accept rs=3 while wb writes r3=0x99 in the same cycle → out_a=0x99, not the old 0x11.
- out_ready=0 for 4 cycles with rs=5; wb writes r5=0x40, then r5=0x41 during hold → out_a=0x41 when released; in_ready=0 throughout the stall.
- Back-to-back accepts of rs=1,2,3 (values 0x01,0x02,0x03), out_ready=1 → out_a=0x01,0x02,0x03 on consecutive cycles, no bubbles.
- Holding valid, assert flush → out_valid=0 next cycle, in_ready=0 during flush; then aclr=0 mid-stall → out_valid=0, out_a=out_b=0, out_tag=0 immediately.
- OPF_ZERO_R0_EN defined: r0 preloaded 0x55, wb writes r0=0x77 at accept, rs=rt=0 → out_a=out_b=0x00. Undefined: same stimulus → 0x77.
